// File: rtl/load_unit_ctrl_if.sv
// Shared load-kind encoding and the issue/memory/writeback bundle of load_unit_ctrl.
// The controller binds to the master modport; the issue stage and memory model use slave.

package load_unit_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [2:0] {
    lk_lb      = 3'd0,
    lk_lh      = 3'd1,
    lk_lw      = 3'd2,
    lk_lbu     = 3'd3,
    lk_lhu     = 3'd4,
    lk_invalid = 3'd5
  } load_kind_t;

endpackage

interface load_unit_ctrl_if;
  import load_unit_ctrl_pkg::*;

  logic              issue_valid;
  logic              issue_ready;
  load_kind_t        issue_kind;
  logic [ADDR_W-1:0] issue_addr;
  logic [RD_W-1:0]   issue_rd;
  logic              flush;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              exc_valid;
  logic [1:0]        exc_cause;
  logic              busy;

  modport master (
    input  issue_valid, issue_kind, issue_addr, issue_rd, flush,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output issue_ready, mem_req_valid, mem_req_addr,
    output wb_valid, wb_rd, wb_data, exc_valid, exc_cause, busy
  );

  modport slave (
    output issue_valid, issue_kind, issue_addr, issue_rd, flush,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  issue_ready, mem_req_valid, mem_req_addr,
    input  wb_valid, wb_rd, wb_data, exc_valid, exc_cause, busy
  );

endinterface

// File: rtl/load_unit_ctrl.sv
// load_unit_ctrl: sequences one RV32I load at a time from issue to the data-memory
// port, extracts/extends the returned byte, half or word, and reports writeback or
// an exception. Optional feature macro: LOAD_MISALIGN_TRAP_EN (misaligned lh/lhu/lw
// trap with cause 01 instead of being silently aligned).

module load_unit_ctrl
  import load_unit_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input logic               clk,
  input logic               rst,
  load_unit_ctrl_if.master  bus
);

  // Counter must hold MAX_WAIT: a flush on the last WAIT cycle steps past MAX_WAIT-1.
  localparam int unsigned    CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_INVALID  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_EXC   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t            r_state;
  load_kind_t        r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic [RD_W-1:0]   r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req_valid;
  logic              r_wb_valid;
  logic [RD_W-1:0]   r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_exc_valid;
  logic [1:0]        r_exc_cause;
  logic              r_busy;

  logic              w_issue_ready;
  logic              w_misaligned;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;

  // A flush in IDLE blocks acceptance in the same cycle.
  assign w_issue_ready = (r_state == S_IDLE) && !bus.flush;

`ifdef LOAD_MISALIGN_TRAP_EN
  // Misalignment judged on the offered load at accept time.
  assign w_misaligned =
      (((bus.issue_kind == lk_lh) || (bus.issue_kind == lk_lhu)) && bus.issue_addr[0]) ||
      ((bus.issue_kind == lk_lw) && (bus.issue_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // Lane selection from the latched byte offset; half uses addr[1] only.
  assign w_byte = 8'(bus.mem_resp_data >> {r_addr[1:0], 3'b000});
  assign w_half = 16'(bus.mem_resp_data >> {r_addr[1], 4'b0000});

  // Sign/zero extension of the selected lane by load kind.
  always_comb begin
    w_ext = bus.mem_resp_data;
    unique case (r_kind)
      lk_lb:   w_ext = {{24{w_byte[7]}}, w_byte};
      lk_lh:   w_ext = {{16{w_half[15]}}, w_half};
      lk_lbu:  w_ext = {24'd0, w_byte};
      lk_lhu:  w_ext = {16'd0, w_half};
      default: w_ext = bus.mem_resp_data;
    endcase
  end

  // Load sequencer with registered request, writeback and exception outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_kind          <= lk_lb;
      r_addr          <= '0;
      r_rd            <= '0;
      r_cnt           <= '0;
      r_mem_req_valid <= 1'b0;
      r_wb_valid      <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_data       <= '0;
      r_exc_valid     <= 1'b0;
      r_exc_cause     <= 2'b00;
      r_busy          <= 1'b0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.issue_valid && w_issue_ready) begin
            r_kind <= bus.issue_kind;
            r_addr <= bus.issue_addr;
            r_rd   <= bus.issue_rd;
            r_busy <= 1'b1;
            if (bus.issue_kind == lk_invalid) begin
              r_state     <= S_EXC;
              r_exc_valid <= 1'b1;
              r_exc_cause <= CAUSE_INVALID;
            end else if (w_misaligned) begin
              r_state     <= S_EXC;
              r_exc_valid <= 1'b1;
              r_exc_cause <= CAUSE_MISALIGN;
            end else begin
              r_state         <= S_REQ;
              r_mem_req_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= bus.flush ? S_DRAIN : S_WAIT;
          end else if (bus.flush) begin
            r_mem_req_valid <= 1'b0;
            r_busy          <= 1'b0;
            r_state         <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            if (bus.mem_resp_valid) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= S_DRAIN;
            end
          end else if (bus.mem_resp_valid) begin
            r_wb_data  <= w_ext;
            r_wb_rd    <= r_rd;
            r_wb_valid <= 1'b1;
            r_state    <= S_WB;
          end else if (r_cnt == CNT_LAST) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= CAUSE_TIMEOUT;
            r_state     <= S_EXC;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (bus.mem_resp_valid || (r_cnt >= CNT_LAST)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WB, S_EXC: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.issue_ready   = w_issue_ready;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_rd         = r_wb_rd;
  assign bus.wb_data       = r_wb_data;
  assign bus.exc_valid     = r_exc_valid;
  assign bus.exc_cause     = r_exc_cause;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Self-checking bench for load_unit_ctrl: directed corner cases plus randomized loads
// checked against an arithmetic reference of the load semantics.

module tb_load_unit_ctrl;
  import load_unit_ctrl_pkg::*;

  localparam int unsigned TB_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_unit_ctrl_if bus ();

  load_unit_ctrl #(.MAX_WAIT(TB_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_wb   = 0;
  int exp_hs   = 0;
  int obs_wb   = 0;
  int obs_hs   = 0;

  // Count writeback pulses and request handshakes as they happen.
  always @(posedge clk) begin
    if (rst) begin
      if (bus.wb_valid) obs_wb <= obs_wb + 1;
      if (bus.mem_req_valid && bus.mem_req_ready) obs_hs <= obs_hs + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference load result from plain arithmetic on the returned word.
  function automatic logic [31:0] ref_load(input load_kind_t k, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] off;
    logic [31:0] hoff;
    logic [31:0] b;
    logic [31:0] h;
    off  = a % 32'd4;
    hoff = (a / 32'd2) % 32'd2;
    b    = (w / (32'd1 << (8 * off))) % 32'd256;
    h    = (w / (32'd1 << (16 * hoff))) % 32'd65536;
    case (k)
      lk_lb:   return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      lk_lh:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      lk_lw:   return w;
      lk_lbu:  return b;
      lk_lhu:  return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_misaligned(input load_kind_t k, input logic [31:0] a);
`ifdef LOAD_MISALIGN_TRAP_EN
    return (((k == lk_lh) || (k == lk_lhu)) && (a % 2 != 0)) || ((k == lk_lw) && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  // Offer one load at a negedge; returns one negedge later (first cycle after accept).
  task automatic issue(input load_kind_t k, input logic [31:0] a, input logic [4:0] rd);
    check("issue_ready", 32'(bus.issue_ready), 32'd1);
    bus.issue_valid = 1'b1;
    bus.issue_kind  = k;
    bus.issue_addr  = a;
    bus.issue_rd    = rd;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.issue_addr  = $urandom;
  endtask

  // Full load: `stall` cycles of request backpressure, response after `d` idle WAIT cycles.
  task automatic run_load(input load_kind_t k, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] word, input int stall, input int d);
    int hs0;
    hs0 = obs_hs;
    issue(k, a, rd);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    if ((k == lk_invalid) || ref_misaligned(k, a)) begin
      check("exc_valid", 32'(bus.exc_valid), 32'd1);
      check("exc_cause", 32'(bus.exc_cause), (k == lk_invalid) ? 32'd3 : 32'd1);
      check("no_mem_req", 32'(bus.mem_req_valid), 32'd0);
      @(negedge clk);
      check("exc_one_pulse", 32'(bus.exc_valid), 32'd0);
      check("idle_after_exc", 32'(bus.busy), 32'd0);
      check("no_hs_on_exc", 32'(obs_hs - hs0), 32'd0);
      return;
    end
    for (int i = 0; i <= stall; i++) begin
      check("mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check("mem_req_addr", bus.mem_req_addr, a - (a % 32'd4));
      bus.mem_req_ready = (i == stall);
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b0;
    exp_hs++;
    check("req_dropped", 32'(bus.mem_req_valid), 32'd0);
    check("one_handshake", 32'(obs_hs - hs0), 32'd1);
    for (int j = 0; j < int'(TB_MAX); j++) begin
      bus.mem_resp_valid = (j == d);
      bus.mem_resp_data  = (j == d) ? word : $urandom;
      @(negedge clk);
      if (j == d) break;
    end
    bus.mem_resp_valid = 1'b0;
    if (d < int'(TB_MAX)) begin
      exp_wb++;
      check("wb_valid", 32'(bus.wb_valid), 32'd1);
      check("wb_rd", 32'(bus.wb_rd), 32'(rd));
      check("wb_data", bus.wb_data, ref_load(k, a, word));
      check("no_exc_on_wb", 32'(bus.exc_valid), 32'd0);
    end else begin
      check("timeout_exc", 32'(bus.exc_valid), 32'd1);
      check("timeout_cause", 32'(bus.exc_cause), 32'd2);
      check("no_wb_on_timeout", 32'(bus.wb_valid), 32'd0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = word;
    end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("wb_one_pulse", 32'(bus.wb_valid), 32'd0);
    check("exc_cleared", 32'(bus.exc_valid), 32'd0);
    check("idle_after_load", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int hs0;
    bus.issue_valid    = 1'b0;
    bus.issue_kind     = lk_lb;
    bus.issue_addr     = '0;
    bus.issue_rd       = '0;
    bus.flush          = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
    check("rst_exc_cause", 32'(bus.exc_cause), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Byte/half extraction and minimum latency.
    run_load(lk_lb,  32'h103, 5'd9,  32'h8012_3456, 0, 0);
    run_load(lk_lhu, 32'h102, 5'd3,  32'hBEEF_1234, 0, 0);
    run_load(lk_lh,  32'h102, 5'd4,  32'hBEEF_1234, 0, 1);
    // Request backpressure: address held for four cycles, one handshake.
    run_load(lk_lw,  32'h200, 5'd12, 32'hCAFE_F00D, 3, 0);
    // Timeout, late response ignored, then a normal load.
    run_load(lk_lw,  32'h300, 5'd1,  32'h1111_2222, 0, int'(TB_MAX));
    run_load(lk_lbu, 32'h302, 5'd2,  32'h00C3_0000, 1, 2);
    // Misaligned word and invalid kind.
    run_load(lk_lw,  32'h101, 5'd5,  32'hA5A5_5A5A, 0, 0);
    run_load(lk_lhu, 32'h103, 5'd6,  32'h8001_7FFE, 0, 0);
    run_load(lk_invalid, 32'h100, 5'd7, 32'h0, 0, 0);

    // Flush in WAIT, response two cycles later is drained.
    issue(lk_lw, 32'h40, 5'd7);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    exp_hs++;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("drain_busy", 32'(bus.busy), 32'd1);
    check("drain_no_wb", 32'(bus.wb_valid), 32'd0);
    @(negedge clk);
    check("drain_busy2", 32'(bus.busy), 32'd1);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("drain_done", 32'(bus.busy), 32'd0);
    check("drain_no_wb2", 32'(bus.wb_valid), 32'd0);
    run_load(lk_lbu, 32'h001, 5'd8, 32'h0000_AB00, 0, 0);

    // Flush in REQ without handshake: nothing issued, flush blocks issue_ready.
    hs0 = obs_hs;
    issue(lk_lw, 32'h80, 5'd10);
    bus.flush = 1'b1;
    @(negedge clk);
    check("req_flush_valid", 32'(bus.mem_req_valid), 32'd0);
    check("req_flush_busy", 32'(bus.busy), 32'd0);
    check("flush_blocks_ready", 32'(bus.issue_ready), 32'd0);
    bus.flush = 1'b0;
    @(negedge clk);
    check("req_flush_no_hs", 32'(obs_hs - hs0), 32'd0);
    check("no_wb_req_flush", 32'(bus.wb_valid), 32'd0);

    // Flush together with handshake goes to drain; drain times out silently.
    issue(lk_lw, 32'h84, 5'd11);
    bus.flush = 1'b1;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.mem_req_ready = 1'b0;
    exp_hs++;
    for (int i = 0; i < int'(TB_MAX); i++) begin
      check("drain_to_busy", 32'(bus.busy), 32'd1);
      check("drain_to_no_exc", 32'(bus.exc_valid), 32'd0);
      @(negedge clk);
    end
    check("drain_to_idle", 32'(bus.busy), 32'd0);
    check("drain_to_silent", 32'(bus.exc_valid), 32'd0);

    // Response and flush in the same WAIT cycle: response dropped.
    issue(lk_lw, 32'h88, 5'd12);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    exp_hs++;
    bus.flush = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 32'h1234_5678;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.mem_resp_valid = 1'b0;
    check("flush_resp_idle", 32'(bus.busy), 32'd0);
    check("flush_resp_no_wb", 32'(bus.wb_valid), 32'd0);
    @(negedge clk);
    check("flush_resp_no_wb2", 32'(bus.wb_valid), 32'd0);

    // Randomized loads.
    for (int n = 0; n < 60; n++) begin
      load_kind_t k;
      int d;
      k = load_kind_t'($urandom_range(0, 5));
      d = ($urandom_range(0, 7) == 0) ? int'(TB_MAX) : int'($urandom_range(0, TB_MAX - 1));
      run_load(k, $urandom, 5'($urandom), $urandom, int'($urandom_range(0, 2)), d);
    end

    check("total_wb", 32'(obs_wb), 32'(exp_wb));
    check("total_hs", 32'(obs_hs), 32'(exp_hs));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
